// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Shares one dual-digit common-select 7-segment display among three BCD
// sources. Source 0 preempts; sources 1 and 2 rotate round-robin after a
// minimum hold. Also owns the digit scan and the BCD-to-segment decode.
module seg_display_arbiter #(
   parameter int CLK_HZ     = 27000000,
   parameter int SCAN_HZ    = 90,
   parameter int HOLD_SCANS = 90
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [2:0] i_req,
   input  logic [7:0] i_data0,
   input  logic [7:0] i_data1,
   input  logic [7:0] i_data2,
   output logic [2:0] o_grant,
   output logic [6:0] o_seg,
   output logic       o_sel,
   output logic       o_busy
);

   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int HOLD_W   = $clog2(HOLD_SCANS + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_SCANS);

   typedef enum logic {IDLE, SHOW} state_t;

   state_t            state_q, state_d;
   logic [2:0]        grant_q, grant_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              last_two_q, last_two_d;   // rr pointer: 1 = source 2 was last of 1/2
   logic [DIV_W-1:0]  div_q;
   logic              tick;
   logic [7:0]        owner_data;
   logic [3:0]        nibble;

   // Winner of a fresh arbitration: source 0 first, else round-robin over 1/2.
   function automatic logic [2:0] pick(input logic [2:0] req, input logic last_two);
      logic [2:0] win;
      win = 3'b000;
      if (req[0])
         win = 3'b001;
      else if (last_two)
         win = req[1] ? 3'b010 : (req[2] ? 3'b100 : 3'b000);
      else
         win = req[2] ? 3'b100 : (req[1] ? 3'b010 : 3'b000);
      return win;
   endfunction

   // Active-low segments, a..g on bits 0..6; non-decimal nibbles show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   assign tick    = (div_q == DIV_LAST);
   assign o_grant = grant_q;

   // Free-running scan divider and digit select; runs in every state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_q <= '0;
         o_sel <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments in clocked blocks so every register
         // samples pre-edge values regardless of statement order.
         div_q <= tick ? '0 : div_q + 1'b1;
         if (tick) o_sel <= ~o_sel;
      end
   end

   // Arbitration state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         grant_q    <= 3'b000;
         hold_q     <= '0;
         last_two_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         hold_q     <= hold_d;
         last_two_q <= last_two_d;
      end
   end

   // Next-state and grant decision; first matching rule wins in SHOW.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d    = state_q;
      grant_d    = grant_q;
      hold_d     = hold_q;
      last_two_d = last_two_q;
      case (state_q)
         IDLE: begin
            hold_d = '0;
            if (|i_req) begin
               grant_d = pick(i_req, last_two_q);
               state_d = SHOW;
            end
         end
         SHOW: begin
            if (tick && hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
            if ((grant_q & i_req) == 3'b000) begin
               grant_d = pick(i_req, last_two_q);
               hold_d  = '0;
               if (grant_d == 3'b000) state_d = IDLE;
            end else if (i_req[0] && !grant_q[0]) begin
               grant_d = 3'b001;
               hold_d  = '0;
            end else if (!grant_q[0] && hold_q == HOLD_MAX &&
                         (|(i_req[2:1] & ~grant_q[2:1]))) begin
               grant_d = {grant_q[1], grant_q[2], 1'b0};
               hold_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (grant_d == 3'b010) last_two_d = 1'b0;
      if (grant_d == 3'b100) last_two_d = 1'b1;
   end

   // Owner's live data and the digit currently being scanned.
   always_comb begin
      owner_data = 8'h00;
      case (grant_q)
         3'b001:  owner_data = i_data0;
         3'b010:  owner_data = i_data1;
         3'b100:  owner_data = i_data2;
         default: owner_data = 8'h00;
      endcase
      nibble = o_sel ? owner_data[7:4] : owner_data[3:0];
   end

   // Registered segment and busy outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_seg  <= 7'h7F;
         o_busy <= 1'b0;
      end else begin
         o_seg  <= (grant_q == 3'b000) ? 7'h7F : seg_decode(nibble);
         o_busy <= |grant_d;
      end
   end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with SCAN_DIV=4, HOLD_SCANS=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg_display_arbiter;

   logic       i_clk;
   logic       i_rst_n;
   logic [2:0] i_req;
   logic [7:0] i_data0, i_data1, i_data2;
   logic [2:0] o_grant;
   logic [6:0] o_seg;
   logic       o_sel;
   logic       o_busy;

   int n_vec;
   int n_bad;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   seg_display_arbiter #(
      .CLK_HZ    (4),
      .SCAN_HZ   (1),
      .HOLD_SCANS(3)
   ) dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_req  (i_req),
      .i_data0(i_data0),
      .i_data1(i_data1),
      .i_data2(i_data2),
      .o_grant(o_grant),
      .o_seg  (o_seg),
      .o_sel  (o_sel),
      .o_busy (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   // Comments give the count of rising edges since reset release (pN).
   initial begin
      n_vec   = 0;
      n_bad   = 0;
      i_rst_n = 1'b1;
      i_req   = 3'b000;
      i_data0 = 8'h00;
      i_data1 = 8'h00;
      i_data2 = 8'h00;

      #2 i_rst_n = 1'b0;
      #1;
      check("rst_grant", {5'd0, o_grant}, 8'h00);
      check("rst_busy",  {7'd0, o_busy},  8'h00);
      check("rst_sel",   {7'd0, o_sel},   8'h00);
      check("rst_seg",   {1'b0, o_seg},   {1'b0, SEG_BLANK});
      step(2);
      i_rst_n = 1'b1;

      // Idle: blank display, o_sel toggles every 4 cycles.
      step(3);                                   // p3
      check("idle_sel_p3",   {7'd0, o_sel},   8'h00);
      check("idle_seg",      {1'b0, o_seg},   {1'b0, SEG_BLANK});
      check("idle_grant",    {5'd0, o_grant}, 8'h00);
      step(1);                                   // p4
      check("idle_sel_p4",   {7'd0, o_sel},   8'h01);
      step(4);                                   // p8
      check("idle_sel_p8",   {7'd0, o_sel},   8'h00);

      // Single request from source 1, value 47.
      i_req   = 3'b010;
      i_data1 = 8'h47;
      step(1);                                   // p9
      check("g1_grant",      {5'd0, o_grant}, 8'h02);
      check("g1_busy",       {7'd0, o_busy},  8'h01);
      check("g1_seg_stale",  {1'b0, o_seg},   {1'b0, SEG_BLANK});
      step(1);                                   // p10
      check("g1_ones7",      {1'b0, o_seg},   {1'b0, SEG_7});
      step(2);                                   // p12
      check("g1_sel_p12",    {7'd0, o_sel},   8'h01);
      check("g1_seg_lag",    {1'b0, o_seg},   {1'b0, SEG_7});
      step(1);                                   // p13
      check("g1_tens4",      {1'b0, o_seg},   {1'b0, SEG_4});

      // Round-robin between 1 and 2, three ticks each.
      i_req = 3'b110;
      step(7);                                   // p20
      check("rr_hold1",      {5'd0, o_grant}, 8'h02);
      step(1);                                   // p21
      check("rr_to2",        {5'd0, o_grant}, 8'h04);
      step(11);                                  // p32
      check("rr_hold2",      {5'd0, o_grant}, 8'h04);
      step(1);                                   // p33
      check("rr_to1",        {5'd0, o_grant}, 8'h02);

      // Source 0 preempts and is never rotated out while requesting.
      i_req   = 3'b111;
      i_data0 = 8'h99;
      step(1);                                   // p34
      check("pre_grant0",    {5'd0, o_grant}, 8'h01);
      step(26);                                  // p60
      check("pre_keep0",     {5'd0, o_grant}, 8'h01);
      check("pre_seg9",      {1'b0, o_seg},   {1'b0, SEG_9});

      // Source 0 drops: grant goes to 2 by rr; A5 shows dash then 5.
      i_req   = 3'b110;
      i_data2 = 8'hA5;
      step(1);                                   // p61
      check("drop0_to2",     {5'd0, o_grant}, 8'h04);
      step(1);                                   // p62
      check("a5_tens_dash",  {1'b0, o_seg},   {1'b0, SEG_DASH});
      step(2);                                   // p64
      check("a5_sel_p64",    {7'd0, o_sel},   8'h00);
      step(1);                                   // p65
      check("a5_ones5",      {1'b0, o_seg},   {1'b0, SEG_5});

      // Asynchronous reset in the middle of SHOW.
      i_rst_n = 1'b0;
      #1;
      check("mid_rst_grant", {5'd0, o_grant}, 8'h00);
      check("mid_rst_busy",  {7'd0, o_busy},  8'h00);
      check("mid_rst_sel",   {7'd0, o_sel},   8'h00);
      check("mid_rst_seg",   {1'b0, o_seg},   {1'b0, SEG_BLANK});
      step(2);
      i_rst_n = 1'b1;
      step(1);                                   // p1
      check("post_rst_1",    {5'd0, o_grant}, 8'h02);

      // Owner drops while source 0 rises: source 0 wins.
      i_req = 3'b101;
      step(1);                                   // p2
      check("drop_rise0",    {5'd0, o_grant}, 8'h01);

      // Source 0 drops with only source 2 left.
      i_req = 3'b100;
      step(1);                                   // p3
      check("rearb_to2",     {5'd0, o_grant}, 8'h04);

      // Everyone drops: back to idle, display blanks a cycle later.
      i_req = 3'b000;
      step(1);                                   // p4
      check("to_idle_grant", {5'd0, o_grant}, 8'h00);
      check("to_idle_busy",  {7'd0, o_busy},  8'h00);
      step(1);                                   // p5
      check("to_idle_seg",   {1'b0, o_seg},   {1'b0, SEG_BLANK});

      // 1 and 2 together from idle: last of 1/2 was 2, so 1 wins.
      i_req = 3'b110;
      step(1);                                   // p6
      check("idle_rr_to1",   {5'd0, o_grant}, 8'h02);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
